// File: rtl/cpu_final_project_cpu_oci_dct_packer_if.sv
// Trace-side bundle for the DCT packer: retire-stage codes in, packed frames out.
// Optional drop_cnt member exists only when CPU_FINAL_PROJECT_DCT_DROP_CNT_EN is defined.
interface cpu_final_project_cpu_oci_dct_packer_if;
  logic        trc_on;
  logic        dct_valid;
  logic [1:0]  dct_code;
  logic        flush;
  logic        frame_ready;
  logic        ovf_clr;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        frame_valid;
  logic [33:0] frame_data;
  logic        overflow;
`ifdef CPU_FINAL_PROJECT_DCT_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  // Handshake: a frame transfers on a clock edge where frame_valid and frame_ready
  // are both high; frame_valid/frame_data hold steady until that edge.
  modport master (
    output trc_on, dct_valid, dct_code, flush, frame_ready, ovf_clr,
    input  dct_buffer, dct_count, frame_valid, frame_data, overflow
`ifdef CPU_FINAL_PROJECT_DCT_DROP_CNT_EN
    , input drop_cnt
`endif
  );

  modport slave (
    input  trc_on, dct_valid, dct_code, flush, frame_ready, ovf_clr,
    output dct_buffer, dct_count, frame_valid, frame_data, overflow
`ifdef CPU_FINAL_PROJECT_DCT_DROP_CNT_EN
    , output drop_cnt
`endif
  );
endinterface

// File: rtl/cpu_final_project_cpu_oci_dct_packer.sv
// Direct-branch compressed-trace packer: shifts 2-bit codes into a 30-bit buffer and
// launches full/flushed frames. Define CPU_FINAL_PROJECT_DCT_DROP_CNT_EN for drop_cnt.
module cpu_final_project_cpu_oci_dct_packer #(
  parameter int MAX_ENTRIES = 15
) (
  input logic clk,
  input logic reset_n,
  cpu_final_project_cpu_oci_dct_packer_if.slave io_trc
);
  localparam logic [3:0] LAST_IDX = 4'(MAX_ENTRIES - 1);

  logic [29:0] r_buf;
  logic [3:0]  r_cnt;
  logic        r_trc_d;
  logic        r_fv;
  logic [33:0] r_fd;
  logic        r_ovf;

  logic        w_accept;
  logic [29:0] w_pk_buf;
  logic [3:0]  w_pk_cnt;
  logic        w_full;
  logic        w_flush_req;
  logic        w_launch;
  logic        w_can_launch;
  logic        w_drop;

  assign w_accept     = io_trc.trc_on & io_trc.dct_valid & (io_trc.dct_code != 2'b00);
  assign w_pk_buf     = w_accept ? {r_buf[27:0], io_trc.dct_code} : r_buf;
  assign w_pk_cnt     = r_cnt + {3'b000, w_accept};
  assign w_full       = w_accept & (r_cnt == LAST_IDX);
  // Falling trc_on acts as an implicit flush so a partial frame is never stranded.
  assign w_flush_req  = io_trc.flush | (r_trc_d & ~io_trc.trc_on);
  assign w_launch     = w_full | (w_flush_req & (w_pk_cnt != 4'd0));
  assign w_can_launch = ~r_fv | io_trc.frame_ready;
  assign w_drop       = w_launch & ~w_can_launch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      r_trc_d <= 1'b0;
      r_fv    <= 1'b0;
      r_fd    <= '0;
    end else begin
      r_trc_d <= io_trc.trc_on;
      if (w_launch) begin
        r_buf <= '0;
        r_cnt <= '0;
      end else begin
        r_buf <= w_pk_buf;
        r_cnt <= w_pk_cnt;
      end
      if (w_launch && w_can_launch) begin
        r_fv <= 1'b1;
        r_fd <= {w_pk_cnt, w_pk_buf};
      end else if (r_fv && io_trc.frame_ready) begin
        r_fv <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             r_ovf <= 1'b0;
    else if (w_drop)          r_ovf <= 1'b1;
    else if (io_trc.ovf_clr)  r_ovf <= 1'b0;
  end

`ifdef CPU_FINAL_PROJECT_DCT_DROP_CNT_EN
  logic [7:0] r_drop_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end else if (io_trc.ovf_clr) begin
      r_drop_cnt <= '0;
    end
  end
  assign io_trc.drop_cnt = r_drop_cnt;
`endif

  assign io_trc.dct_buffer  = r_buf;
  assign io_trc.dct_count   = r_cnt;
  assign io_trc.frame_valid = r_fv;
  assign io_trc.frame_data  = r_fd;
  assign io_trc.overflow    = r_ovf;
endmodule
